// File: rtl/vstu_w_buffer_pkg.sv
// Shared types, sizing helpers and defaults for the vector store W-beat buffer.
// The AXI W/B payload structs here are the defaults used by the buffer and its interface.
package vstu_w_buffer_pkg;

    localparam int unsigned VstuWBufDepth = 4;
    localparam int unsigned VstuMaxBursts = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } vstu_axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        resp_t      resp;
        logic       user;
    } vstu_axi_b_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic resp_is_err(input resp_t r);
        return (r == RESP_SLVERR) || (r == RESP_DECERR);
    endfunction

endpackage

// File: rtl/vstu_w_buffer_if.sv
// W and B channel bundle between the store unit, the W buffer and the AXI side.
// Signal directions are named from the buffer's point of view.
interface vstu_w_buffer_if
    import vstu_w_buffer_pkg::*;
();

    vstu_axi_w_t vstu_w_i;
    logic        vstu_w_valid_i;
    logic        vstu_w_ready_o;

    vstu_axi_w_t axi_w_o;
    logic        axi_w_valid_o;
    logic        axi_w_ready_i;

    vstu_axi_b_t axi_b_i;
    logic        axi_b_valid_i;
    logic        axi_b_ready_o;

    vstu_axi_b_t vstu_b_o;
    logic        vstu_b_valid_o;
    logic        vstu_b_ready_i;

    modport slave (
        input  vstu_w_i, vstu_w_valid_i,
        output vstu_w_ready_o,
        output axi_w_o, axi_w_valid_o,
        input  axi_w_ready_i,
        input  axi_b_i, axi_b_valid_i,
        output axi_b_ready_o,
        output vstu_b_o, vstu_b_valid_o,
        input  vstu_b_ready_i
    );

    modport master (
        output vstu_w_i, vstu_w_valid_i,
        input  vstu_w_ready_o,
        input  axi_w_o, axi_w_valid_o,
        output axi_w_ready_i,
        output axi_b_i, axi_b_valid_i,
        input  axi_b_ready_o,
        input  vstu_b_o, vstu_b_valid_o,
        output vstu_b_ready_i
    );

endinterface

// File: rtl/vstu_w_buffer_fifo.sv
// Non-fall-through FIFO: the head entry is read from storage, so data pushed in one
// cycle is visible on data_o no earlier than the next cycle.
module vstu_w_buffer_fifo
    import vstu_w_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type dtype = logic,
    localparam int unsigned AddrWidth = idx_width(DEPTH)
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    dtype                 mem_q [DEPTH];
    logic [AddrWidth-1:0] wptr_q, wptr_d;
    logic [AddrWidth-1:0] rptr_q, rptr_d;
    logic [AddrWidth:0]   cnt_q, cnt_d;
    logic                 push, pop;

    assign full_o  = (cnt_q == (AddrWidth+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AddrWidth'(1);
        if (pop)  rptr_d = rptr_q + AddrWidth'(1);
        if (push && !pop)      cnt_d = cnt_q + (AddrWidth+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AddrWidth+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vstu_w_buffer.sv
// Buffers store-unit W beats toward AXI, caps bursts awaiting B, and passes B responses
// back upstream while recording sticky error and unexpected-response flags.
module vstu_w_buffer
    import vstu_w_buffer_pkg::*;
#(
    parameter int unsigned WDepth    = VstuWBufDepth,
    parameter int unsigned MaxBursts = VstuMaxBursts,
    parameter type axi_w_t = vstu_axi_w_t,
    parameter type axi_b_t = vstu_axi_b_t,
    localparam int unsigned CntWidth = idx_width(MaxBursts) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    vstu_w_buffer_if.slave      bus,
    input  logic                err_clr_i,
    output logic                b_err_o,
    output logic                b_unexp_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                idle_o
);

    logic                w_full, w_empty, w_push, w_pop, w_offer, cap_ok;
    axi_w_t              w_in, w_head;
    axi_b_t              b_in;
    logic                b_hs, burst_inc, burst_dec;
    logic [CntWidth-1:0] outstanding_q, outstanding_d;
    logic                b_err_q, b_err_d;
    logic                b_unexp_q, b_unexp_d;

    assign w_in   = bus.vstu_w_i;
    assign w_push = bus.vstu_w_valid_i && !w_full;

    vstu_w_buffer_fifo #(
        .DEPTH (WDepth),
        .dtype (axi_w_t)
    ) i_w_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (w_in),
        .push_i  (w_push),
        .data_o  (w_head),
        .pop_i   (w_pop)
    );

    // Outstanding only grows by popping this same head, so once a held last beat is
    // offered the cap condition cannot revert before its handshake.
    assign cap_ok  = (outstanding_q < CntWidth'(MaxBursts)) || !w_head.last;
    assign w_offer = !w_empty && cap_ok;
    assign w_pop   = w_offer && bus.axi_w_ready_i;

    assign bus.vstu_w_ready_o = !w_full;
    assign bus.axi_w_valid_o  = w_offer;
    assign bus.axi_w_o        = w_head;

    assign b_in               = bus.axi_b_i;
    assign bus.vstu_b_o       = b_in;
    assign bus.vstu_b_valid_o = bus.axi_b_valid_i;
    assign bus.axi_b_ready_o  = bus.vstu_b_ready_i;

    assign b_hs      = bus.axi_b_valid_i && bus.vstu_b_ready_i;
    assign burst_inc = w_pop && w_head.last;
    assign burst_dec = b_hs && (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (burst_inc && !burst_dec)      outstanding_d = outstanding_q + CntWidth'(1);
        else if (burst_dec && !burst_inc) outstanding_d = outstanding_q - CntWidth'(1);
    end

    // A new error in the clear cycle must survive, so set takes priority.
    always_comb begin
        b_err_d   = b_err_q;
        b_unexp_d = b_unexp_q;
        if (err_clr_i) begin
            b_err_d   = 1'b0;
            b_unexp_d = 1'b0;
        end
        if (b_hs && resp_is_err(b_in.resp)) b_err_d   = 1'b1;
        if (b_hs && (outstanding_q == '0))  b_unexp_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            b_err_q       <= 1'b0;
            b_unexp_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            b_err_q       <= b_err_d;
            b_unexp_q     <= b_unexp_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign b_err_o       = b_err_q;
    assign b_unexp_o     = b_unexp_q;
    assign idle_o        = w_empty && (outstanding_q == '0);

endmodule

// File: tb/tb_vstu_w_buffer.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_vstu_w_buffer;
    import vstu_w_buffer_pkg::*;

    localparam int WD = 4;
    localparam int MB = 2;
    localparam int CW = idx_width(MB) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_clr = 1'b0;
    logic          b_err, b_unexp, idle;
    logic [CW-1:0] outstanding;

    int n_checks = 0;
    int n_fail = 0;

    vstu_axi_w_t m_q[$];
    int          m_out;
    bit          m_err, m_unexp;

    always #5 clk = ~clk;

    vstu_w_buffer_if bus ();

    vstu_w_buffer #(
        .WDepth    (WD),
        .MaxBursts (MB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .err_clr_i     (err_clr),
        .b_err_o       (b_err),
        .b_unexp_o     (b_unexp),
        .outstanding_o (outstanding),
        .idle_o        (idle)
    );

    function automatic vstu_axi_w_t mk_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        vstu_axi_w_t b;
        b.data = d;
        b.strb = s;
        b.last = l;
        b.user = 1'b0;
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vstu_w_i       = '0;
        bus.vstu_w_valid_i = 1'b0;
        bus.axi_w_ready_i  = 1'b0;
        bus.axi_b_i        = '0;
        bus.axi_b_valid_i  = 1'b0;
        bus.vstu_b_ready_i = 1'b0;
        err_clr            = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        m_q.delete();
        m_out   = 0;
        m_err   = 0;
        m_unexp = 0;
    endtask

    task automatic send_b(input resp_t r);
        bus.axi_b_i        = '{id: 4'h5, resp: r, user: 1'b0};
        bus.axi_b_valid_i  = 1'b1;
        bus.vstu_b_ready_i = 1'b1;
        cyc();
        bus.axi_b_valid_i  = 1'b0;
        bus.vstu_b_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bus.vstu_w_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_w_ready: got %b want 1", bus.vstu_w_ready_o); end
        n_checks++; if (bus.axi_w_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b want 0", bus.axi_w_valid_o); end
        n_checks++; if (bus.axi_w_o !== '0) begin n_fail++; $display("FAIL reset_w_data: got %h want 0", bus.axi_w_o); end
        n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_checks++; if ({b_err, b_unexp} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {b_err, b_unexp}); end
        n_checks++; if ({bus.vstu_b_valid_o, bus.axi_b_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_b_path: got %b want 00", {bus.vstu_b_valid_o, bus.axi_b_ready_o}); end
        do_reset();
    endtask

    task automatic test_single_beat();
        vstu_axi_w_t beat;
        vstu_axi_b_t bexp;
        do_reset();
        beat = mk_beat(64'hDEAD, 8'hFF, 1'b1);
        bus.axi_w_ready_i  = 1'b1;
        bus.vstu_w_i       = beat;
        bus.vstu_w_valid_i = 1'b1;
        #1;
        n_checks++; if (bus.axi_w_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", bus.axi_w_valid_o); end
        cyc();
        bus.vstu_w_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.axi_w_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid_latency: got %b want 1", bus.axi_w_valid_o); end
        n_checks++; if (bus.axi_w_o !== beat) begin n_fail++; $display("FAIL single_data: got %h want %h", bus.axi_w_o, beat); end
        cyc();
        n_checks++; if (outstanding !== CW'(1)) begin n_fail++; $display("FAIL single_outstanding_inc: got %0d want 1", outstanding); end
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_not_idle: got %b want 0", idle); end
        bexp = '{id: 4'h3, resp: RESP_OKAY, user: 1'b1};
        bus.axi_b_i        = bexp;
        bus.axi_b_valid_i  = 1'b1;
        bus.vstu_b_ready_i = 1'b1;
        #1;
        n_checks++; if ({bus.vstu_b_valid_o, bus.axi_b_ready_o} !== 2'b11) begin n_fail++; $display("FAIL single_b_pass: got %b want 11", {bus.vstu_b_valid_o, bus.axi_b_ready_o}); end
        n_checks++; if (bus.vstu_b_o !== bexp) begin n_fail++; $display("FAIL single_b_data: got %h want %h", bus.vstu_b_o, bexp); end
        cyc();
        bus.axi_b_valid_i  = 1'b0;
        bus.vstu_b_ready_i = 1'b0;
        #1;
        n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL single_outstanding_dec: got %0d want 0", outstanding); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL single_no_err: got %b want 0", b_err); end
    endtask

    task automatic test_backpressure();
        vstu_axi_w_t bp [5];
        do_reset();
        bus.axi_w_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bp[i] = mk_beat(64'h1000 + 64'(i), 8'(i + 1), 1'b0);
            bus.vstu_w_i       = bp[i];
            bus.vstu_w_valid_i = 1'b1;
            #1;
            n_checks++; if (bus.vstu_w_ready_o !== (i < 4)) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want %b", i, bus.vstu_w_ready_o, (i < 4)); end
            if (i < 4) cyc();
        end
        bus.axi_w_ready_i = 1'b1;
        #1;
        n_checks++; if (bus.axi_w_o !== bp[0] || bus.axi_w_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_head0: got %h v%b want %h", bus.axi_w_o, bus.axi_w_valid_o, bp[0]); end
        cyc();
        n_checks++; if (bus.vstu_w_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.vstu_w_ready_o); end
        n_checks++; if (bus.axi_w_o !== bp[1]) begin n_fail++; $display("FAIL bp_head1: got %h want %h", bus.axi_w_o, bp[1]); end
        cyc();
        bus.vstu_w_valid_i = 1'b0;
        for (int k = 2; k < 5; k++) begin
            #1;
            n_checks++; if (bus.axi_w_valid_o !== 1'b1 || bus.axi_w_o !== bp[k]) begin n_fail++; $display("FAIL bp_order_%0d: got %h v%b want %h", k, bus.axi_w_o, bus.axi_w_valid_o, bp[k]); end
            cyc();
        end
        n_checks++; if (bus.axi_w_valid_o !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL bp_drained: got v%b idle%b want v0 idle1", bus.axi_w_valid_o, idle); end
    endtask

    task automatic test_cap();
        vstu_axi_w_t cb [3];
        do_reset();
        bus.axi_w_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cb[i] = mk_beat(64'hC0DE_0000 + 64'(i), 8'hF0, 1'b1);
            bus.vstu_w_i       = cb[i];
            bus.vstu_w_valid_i = 1'b1;
            cyc();
        end
        bus.vstu_w_valid_i = 1'b0;
        repeat (2) cyc();
        n_checks++; if (bus.axi_w_valid_o !== 1'b0) begin n_fail++; $display("FAIL cap_held: got %b want 0", bus.axi_w_valid_o); end
        n_checks++; if (outstanding !== CW'(MB)) begin n_fail++; $display("FAIL cap_outstanding: got %0d want %0d", outstanding, MB); end
        send_b(RESP_OKAY);
        #1;
        n_checks++; if (bus.axi_w_valid_o !== 1'b1 || bus.axi_w_o !== cb[2]) begin n_fail++; $display("FAIL cap_release: got %h v%b want %h", bus.axi_w_o, bus.axi_w_valid_o, cb[2]); end
        cyc();
        n_checks++; if (outstanding !== CW'(MB) || bus.axi_w_valid_o !== 1'b0) begin n_fail++; $display("FAIL cap_after_release: got %0d v%b want %0d v0", outstanding, bus.axi_w_valid_o, MB); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.axi_w_ready_i  = 1'b1;
        bus.vstu_w_i       = mk_beat(64'hA1, 8'h01, 1'b1);
        bus.vstu_w_valid_i = 1'b1;
        cyc();
        bus.vstu_w_valid_i = 1'b0;
        cyc();
        bus.axi_w_ready_i  = 1'b0;
        bus.vstu_w_i       = mk_beat(64'hA2, 8'h02, 1'b1);
        bus.vstu_w_valid_i = 1'b1;
        cyc();
        bus.vstu_w_valid_i = 1'b0;
        #1;
        n_checks++; if (outstanding !== CW'(1) || bus.axi_w_valid_o !== 1'b1) begin n_fail++; $display("FAIL simul_setup: got %0d v%b want 1 v1", outstanding, bus.axi_w_valid_o); end
        bus.axi_w_ready_i = 1'b1;
        send_b(RESP_OKAY);
        n_checks++; if (outstanding !== CW'(1)) begin n_fail++; $display("FAIL simul_inc_dec: got %0d want 1", outstanding); end
    endtask

    task automatic test_errors();
        do_reset();
        bus.axi_w_ready_i  = 1'b1;
        bus.vstu_w_i       = mk_beat(64'hE0, 8'h0F, 1'b1);
        bus.vstu_w_valid_i = 1'b1;
        cyc();
        bus.vstu_w_valid_i = 1'b0;
        cyc();
        bus.axi_b_i        = '{id: 4'h1, resp: RESP_SLVERR, user: 1'b0};
        bus.axi_b_valid_i  = 1'b1;
        bus.vstu_b_ready_i = 1'b1;
        #1;
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL err_not_early: got %b want 0", b_err); end
        cyc();
        bus.axi_b_valid_i  = 1'b0;
        bus.vstu_b_ready_i = 1'b0;
        n_checks++; if ({b_err, b_unexp} !== 2'b10 || outstanding !== '0) begin n_fail++; $display("FAIL err_slverr: got flags %b cnt %0d want 10 cnt 0", {b_err, b_unexp}, outstanding); end
        repeat (2) cyc();
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", b_err); end
        bus.axi_b_i        = '{id: 4'h2, resp: RESP_OKAY, user: 1'b0};
        bus.axi_b_valid_i  = 1'b1;
        bus.vstu_b_ready_i = 1'b1;
        #1;
        n_checks++; if (bus.vstu_b_valid_o !== 1'b1) begin n_fail++; $display("FAIL unexp_forwarded: got %b want 1", bus.vstu_b_valid_o); end
        cyc();
        bus.axi_b_valid_i  = 1'b0;
        bus.vstu_b_ready_i = 1'b0;
        n_checks++; if ({b_err, b_unexp} !== 2'b11 || outstanding !== '0) begin n_fail++; $display("FAIL unexp_set: got flags %b cnt %0d want 11 cnt 0", {b_err, b_unexp}, outstanding); end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        n_checks++; if ({b_err, b_unexp} !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b want 00", {b_err, b_unexp}); end
        err_clr = 1'b1;
        send_b(RESP_DECERR);
        err_clr = 1'b0;
        n_checks++; if ({b_err, b_unexp} !== 2'b11) begin n_fail++; $display("FAIL err_set_wins: got %b want 11", {b_err, b_unexp}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.axi_w_ready_i  = 1'b1;
        bus.vstu_w_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.vstu_w_i = mk_beat(64'hB0 + 64'(i), 8'h11, 1'b1);
            cyc();
        end
        bus.vstu_w_valid_i = 1'b0;
        cyc();
        bus.axi_w_ready_i  = 1'b0;
        bus.vstu_w_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.vstu_w_i = mk_beat(64'hD0 + 64'(i), 8'h22, 1'b0);
            cyc();
        end
        bus.vstu_w_valid_i = 1'b0;
        #1;
        n_checks++; if (outstanding !== CW'(2) || bus.axi_w_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got %0d v%b want 2 v1", outstanding, bus.axi_w_valid_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (outstanding !== '0 || bus.axi_w_valid_o !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rmid_async: got cnt %0d v%b idle%b want 0 0 1", outstanding, bus.axi_w_valid_o, idle); end
        n_checks++; if (bus.vstu_w_ready_o !== 1'b1 || bus.axi_w_o !== '0) begin n_fail++; $display("FAIL rmid_fifo: got rdy%b data %h want 1 0", bus.vstu_w_ready_o, bus.axi_w_o); end
        do_reset();
    endtask

    task automatic test_random();
        vstu_axi_w_t beat;
        bit          exp_ready, exp_valid, push, pop, bhs;
        int          o;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            beat = mk_beat({$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 2) == 0));
            bus.vstu_w_i       = beat;
            bus.vstu_w_valid_i = 1'($urandom_range(0, 1));
            bus.axi_w_ready_i  = 1'($urandom_range(0, 3) != 0);
            bus.axi_b_i        = '{id: 4'($urandom), resp: resp_t'($urandom_range(0, 3)), user: 1'($urandom)};
            bus.axi_b_valid_i  = 1'($urandom_range(0, 2) == 0);
            bus.vstu_b_ready_i = 1'($urandom_range(0, 1));
            err_clr            = 1'($urandom_range(0, 15) == 0);
            #1;
            exp_ready = (m_q.size() < WD);
            exp_valid = (m_q.size() > 0) && ((m_out < MB) || !m_q[0].last);
            n_checks++; if (bus.vstu_w_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_w_ready c%0d: got %b want %b", c, bus.vstu_w_ready_o, exp_ready); end
            n_checks++; if (bus.axi_w_valid_o !== exp_valid) begin n_fail++; $display("FAIL rnd_w_valid c%0d: got %b want %b", c, bus.axi_w_valid_o, exp_valid); end
            if (exp_valid) begin
                n_checks++; if (bus.axi_w_o !== m_q[0]) begin n_fail++; $display("FAIL rnd_w_data c%0d: got %h want %h", c, bus.axi_w_o, m_q[0]); end
            end
            n_checks++; if (outstanding !== CW'(m_out)) begin n_fail++; $display("FAIL rnd_outstanding c%0d: got %0d want %0d", c, outstanding, m_out); end
            n_checks++; if (idle !== (m_q.size() == 0 && m_out == 0)) begin n_fail++; $display("FAIL rnd_idle c%0d: got %b", c, idle); end
            n_checks++; if ({b_err, b_unexp} !== {m_err, m_unexp}) begin n_fail++; $display("FAIL rnd_flags c%0d: got %b want %b", c, {b_err, b_unexp}, {m_err, m_unexp}); end
            n_checks++; if (bus.vstu_b_o !== bus.axi_b_i || bus.vstu_b_valid_o !== bus.axi_b_valid_i || bus.axi_b_ready_o !== bus.vstu_b_ready_i) begin n_fail++; $display("FAIL rnd_b_path c%0d: got %h v%b r%b", c, bus.vstu_b_o, bus.vstu_b_valid_o, bus.axi_b_ready_o); end
            push = bus.vstu_w_valid_i && exp_ready;
            pop  = exp_valid && bus.axi_w_ready_i;
            bhs  = bus.axi_b_valid_i && bus.vstu_b_ready_i;
            o    = m_out;
            if (pop) begin
                if (m_q[0].last) m_out++;
                void'(m_q.pop_front());
            end
            if (push) m_q.push_back(beat);
            if (bhs && o != 0) m_out--;
            m_err   = (bhs && resp_is_err(bus.axi_b_i.resp)) ? 1'b1 : (err_clr ? 1'b0 : m_err);
            m_unexp = (bhs && o == 0) ? 1'b1 : (err_clr ? 1'b0 : m_unexp);
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_cap();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
